// File: rtl/io_bus_bridge.sv
// Round-robin bridge from per-core I/O request queues to a single
// memory-mapped peripheral bus with acknowledge and wait-state timeout.
module io_bus_bridge #(
  parameter int NUM_CORES        = 1,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int THREAD_IDX_WIDTH = 2,
  localparam int CORE_IDX_WIDTH  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CORES-1:0]                 ior_request_valid,
  input  logic [NUM_CORES-1:0]                 ior_request_is_store,
  input  logic [NUM_CORES*32-1:0]              ior_request_address,
  input  logic [NUM_CORES*32-1:0]              ior_request_value,
  input  logic [NUM_CORES*THREAD_IDX_WIDTH-1:0] ior_request_thread_idx,
  output logic [NUM_CORES-1:0]                 ii_ready,
  output logic                                 ii_response_valid,
  output logic [CORE_IDX_WIDTH-1:0]            ii_response_core,
  output logic [THREAD_IDX_WIDTH-1:0]          ii_response_thread_idx,
  output logic [31:0]                          ii_response_read_value,
  output logic                                 io_read_en,
  output logic                                 io_write_en,
  output logic [31:0]                          io_address,
  output logic [31:0]                          io_write_data,
  input  logic                                 io_ack,
  input  logic [31:0]                          io_read_data,
  output logic                                 io_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                        state_r, state_nx_s;
  logic [CORE_IDX_WIDTH-1:0]     prio_r;
  logic [15:0]                   wait_cnt_r;
  logic                          is_store_r;
  logic [31:0]                   address_r, write_data_r, value_r;
  logic [THREAD_IDX_WIDTH-1:0]   thread_r;
  logic [CORE_IDX_WIDTH-1:0]     core_r;
  logic                          timeout_r, timeout_s;

  logic                          found_hi_s, found_lo_s, found_s;
  logic [CORE_IDX_WIDTH-1:0]     idx_hi_s, idx_lo_s, grant_idx_s;
  logic [NUM_CORES-1:0]          grant_oh_s;
  logic                          sel_store_s;
  logic [31:0]                   sel_addr_s, sel_value_s;
  logic [THREAD_IDX_WIDTH-1:0]   sel_thread_s;

  // Round-robin arbiter: lowest index at or above prio_r wins, else lowest overall.
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    idx_hi_s   = '0;
    idx_lo_s   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (ior_request_valid[i]) begin
        if (i >= int'(prio_r)) begin
          found_hi_s = 1'b1;
          idx_hi_s   = CORE_IDX_WIDTH'(i);
        end else begin
          found_lo_s = 1'b1;
          idx_lo_s   = CORE_IDX_WIDTH'(i);
        end
      end else begin
        found_hi_s = found_hi_s;
      end
    end
    found_s     = found_hi_s | found_lo_s;
    grant_idx_s = found_hi_s ? idx_hi_s : idx_lo_s;
    grant_oh_s  = (found_s && (state_r == IDLE)) ? (NUM_CORES'(1) << grant_idx_s) : '0;
  end

  // Select the granted core's request fields.
  always_comb begin
    sel_store_s  = 1'b0;
    sel_addr_s   = 32'd0;
    sel_value_s  = 32'd0;
    sel_thread_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (CORE_IDX_WIDTH'(i) == grant_idx_s) begin
        sel_store_s  = ior_request_is_store[i];
        sel_addr_s   = ior_request_address[i*32 +: 32];
        sel_value_s  = ior_request_value[i*32 +: 32];
        sel_thread_s = ior_request_thread_idx[i*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
      end else begin
        sel_store_s = sel_store_s;
      end
    end
  end

  // Next-state logic; ack in the timeout cycle takes precedence.
  always_comb begin
    state_nx_s = state_r;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nx_s = BUS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUS: begin
        if (io_ack) begin
          state_nx_s = RESP;
        end else if (wait_cnt_r == 16'(TIMEOUT_CYCLES)) begin
          state_nx_s = RESP;
          timeout_s  = 1'b1;
        end else begin
          state_nx_s = BUS;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Transaction latches, wait counter, response value and LRU pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_r       <= '0;
      wait_cnt_r   <= 16'd0;
      is_store_r   <= 1'b0;
      address_r    <= 32'd0;
      write_data_r <= 32'd0;
      value_r      <= 32'd0;
      thread_r     <= '0;
      core_r       <= '0;
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= timeout_s;
      case (state_r)
        IDLE: begin
          wait_cnt_r <= 16'd0;
          if (found_s) begin
            is_store_r   <= sel_store_s;
            address_r    <= sel_addr_s;
            write_data_r <= sel_value_s;
            thread_r     <= sel_thread_s;
            core_r       <= grant_idx_s;
            if (int'(grant_idx_s) == NUM_CORES - 1) begin
              prio_r <= '0;
            end else begin
              prio_r <= grant_idx_s + 1'b1;
            end
          end
        end
        BUS: begin
          if (io_ack) begin
            value_r <= is_store_r ? 32'd0 : io_read_data;
          end else if (wait_cnt_r == 16'(TIMEOUT_CYCLES)) begin
            value_r <= is_store_r ? 32'd0 : 32'hFFFF_FFFF;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        RESP:    wait_cnt_r <= 16'd0;
        default: wait_cnt_r <= 16'd0;
      endcase
    end
  end

  assign ii_ready               = grant_oh_s;
  assign ii_response_valid      = (state_r == RESP);
  assign ii_response_core       = core_r;
  assign ii_response_thread_idx = thread_r;
  assign ii_response_read_value = value_r;
  assign io_read_en             = (state_r == BUS) && !is_store_r;
  assign io_write_en            = (state_r == BUS) && is_store_r;
  assign io_address             = address_r;
  assign io_write_data          = write_data_r;
  assign io_timeout             = timeout_r;

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge: four cores, short timeout, scoreboarded responses.
module tb_io_bus_bridge;
  localparam int NC = 4;
  localparam int TW = 2;
  localparam int CW = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        ior_request_valid, ior_request_is_store;
  logic [NC*32-1:0]     ior_request_address, ior_request_value;
  logic [NC*TW-1:0]     ior_request_thread_idx;
  logic [NC-1:0]        ii_ready;
  logic                 ii_response_valid;
  logic [CW-1:0]        ii_response_core;
  logic [TW-1:0]        ii_response_thread_idx;
  logic [31:0]          ii_response_read_value;
  logic                 io_read_en, io_write_en, io_ack, io_timeout;
  logic [31:0]          io_address, io_write_data, io_read_data;

  typedef struct packed {
    logic [CW-1:0] core;
    logic [TW-1:0] thread;
    logic [31:0]   value;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  io_bus_bridge #(.NUM_CORES(NC), .TIMEOUT_CYCLES(4), .THREAD_IDX_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .ior_request_valid(ior_request_valid), .ior_request_is_store(ior_request_is_store),
    .ior_request_address(ior_request_address), .ior_request_value(ior_request_value),
    .ior_request_thread_idx(ior_request_thread_idx),
    .ii_ready(ii_ready), .ii_response_valid(ii_response_valid),
    .ii_response_core(ii_response_core), .ii_response_thread_idx(ii_response_thread_idx),
    .ii_response_read_value(ii_response_read_value),
    .io_read_en(io_read_en), .io_write_en(io_write_en), .io_address(io_address),
    .io_write_data(io_write_data), .io_ack(io_ack), .io_read_data(io_read_data),
    .io_timeout(io_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic v, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [TW-1:0] t);
    ior_request_valid[c]              = v;
    ior_request_is_store[c]           = st;
    ior_request_address[c*32 +: 32]   = a;
    ior_request_value[c*32 +: 32]     = d;
    ior_request_thread_idx[c*TW +: TW] = t;
  endtask

  task automatic expect_resp(input string tag);
    rsp_t e;
    chk({tag, "_valid"}, 32'(ii_response_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_core"},   32'(ii_response_core),       32'(e.core));
      chk({tag, "_thread"}, 32'(ii_response_thread_idx), 32'(e.thread));
      chk({tag, "_value"},  ii_response_read_value,      e.value);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},   32'(ii_ready), 32'd0);
    chk({tag, "_rvalid"},  32'(ii_response_valid), 32'd0);
    chk({tag, "_rd_en"},   32'(io_read_en), 32'd0);
    chk({tag, "_wr_en"},   32'(io_write_en), 32'd0);
    chk({tag, "_addr"},    io_address, 32'd0);
    chk({tag, "_wdata"},   io_write_data, 32'd0);
    chk({tag, "_timeout"}, 32'(io_timeout), 32'd0);
    chk({tag, "_rcore"},   32'(ii_response_core), 32'd0);
    chk({tag, "_rthread"}, 32'(ii_response_thread_idx), 32'd0);
    chk({tag, "_rvalue"},  ii_response_read_value, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ior_request_valid = '0; ior_request_is_store = '0;
    ior_request_address = '0; ior_request_value = '0; ior_request_thread_idx = '0;
    io_ack = 1'b0; io_read_data = 32'd0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");

    // Round robin from reset: all four cores request continuously.
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NC; c++) set_req(c, 1'b1, 1'b0, 32'hFFFF_1000 + 32'(c * 4), 32'd0, TW'(c));
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NC;
      #1 chk("rr_grant", 32'(ii_ready), 32'(1 << g));
      exp_q.push_back('{core: CW'(g), thread: TW'(g), value: 32'hA000_0000 + 32'(k)});
      @(negedge clk);
      io_ack = 1'b1; io_read_data = 32'hA000_0000 + 32'(k);
      #1 chk("rr_bus_ready", 32'(ii_ready), 32'd0);
      chk("rr_rd_en", 32'(io_read_en), 32'd1);
      chk("rr_addr", io_address, 32'hFFFF_1000 + 32'(g * 4));
      @(negedge clk);
      io_ack = 1'b0;
      #1 expect_resp("rr_resp");
      chk("rr_resp_ready", 32'(ii_ready), 32'd0);
      @(negedge clk);
    end
    for (int c = 0; c < NC; c++) ior_request_valid[c] = 1'b0;
    #1 chk("rr_idle_ready", 32'(ii_ready), 32'd0);

    // Single load, zero wait states.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'hFFFF_0004, 32'd0, 2'd2);
    exp_q.push_back('{core: 2'd0, thread: 2'd2, value: 32'h1234_5678});
    #1 chk("ld_ready", 32'(ii_ready), 32'b0001);
    @(negedge clk);
    ior_request_valid[0] = 1'b0; io_ack = 1'b1; io_read_data = 32'h1234_5678;
    #1 chk("ld_rd_en", 32'(io_read_en), 32'd1);
    chk("ld_wr_en", 32'(io_write_en), 32'd0);
    chk("ld_addr", io_address, 32'hFFFF_0004);
    @(negedge clk);
    io_ack = 1'b0; io_read_data = 32'd0;
    #1 expect_resp("ld_resp");
    @(negedge clk);
    #1 chk("ld_valid_once", 32'(ii_response_valid), 32'd0);

    // Store with three wait states.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'hFFFF_0100, 32'hDEAD_BEEF, 2'd1);
    exp_q.push_back('{core: 2'd0, thread: 2'd1, value: 32'd0});
    #1 chk("st_ready", 32'(ii_ready), 32'b0001);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ior_request_valid[0] = 1'b0; io_ack = (i == 4);
      #1 chk("st_wr_en", 32'(io_write_en), 32'd1);
      chk("st_rd_en", 32'(io_read_en), 32'd0);
      chk("st_addr", io_address, 32'hFFFF_0100);
      chk("st_wdata", io_write_data, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    io_ack = 1'b0;
    #1 expect_resp("st_resp");
    chk("st_wr_en_off", 32'(io_write_en), 32'd0);
    chk("st_no_timeout", 32'(io_timeout), 32'd0);

    // Timeout with no acknowledge.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'hFFFF_0200, 32'd0, 2'd3);
    exp_q.push_back('{core: 2'd0, thread: 2'd3, value: 32'hFFFF_FFFF});
    #1 chk("to_ready", 32'(ii_ready), 32'b0001);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ior_request_valid[0] = 1'b0;
      #1 chk("to_rd_en", 32'(io_read_en), 32'd1);
      chk("to_early_timeout", 32'(io_timeout), 32'd0);
    end
    @(negedge clk);
    #1 chk("to_rd_en_off", 32'(io_read_en), 32'd0);
    chk("to_pulse", 32'(io_timeout), 32'd1);
    expect_resp("to_resp");
    @(negedge clk);
    #1 chk("to_pulse_end", 32'(io_timeout), 32'd0);

    // Acknowledge in the final cycle beats the timeout.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'hFFFF_0200, 32'd0, 2'd3);
    exp_q.push_back('{core: 2'd0, thread: 2'd3, value: 32'h5A5A_5A5A});
    #1 chk("tack_ready", 32'(ii_ready), 32'b0001);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ior_request_valid[0] = 1'b0; io_ack = (i == 5); io_read_data = 32'h5A5A_5A5A;
      #1 chk("tack_rd_en", 32'(io_read_en), 32'd1);
    end
    @(negedge clk);
    io_ack = 1'b0;
    #1 chk("tack_no_timeout", 32'(io_timeout), 32'd0);
    expect_resp("tack_resp");

    // Core 1 requests during the response of core 0.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 32'hFFFF_0300, 32'd0, 2'd0);
    exp_q.push_back('{core: 2'd0, thread: 2'd0, value: 32'h1111_1111});
    #1 chk("bp_ready0", 32'(ii_ready), 32'b0001);
    @(negedge clk);
    ior_request_valid[0] = 1'b0; io_ack = 1'b1; io_read_data = 32'h1111_1111;
    #1 chk("bp_rd_en", 32'(io_read_en), 32'd1);
    @(negedge clk);
    io_ack = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'hFFFF_0304, 32'd0, 2'd1);
    #1 chk("bp_resp_ready", 32'(ii_ready), 32'd0);
    expect_resp("bp_resp0");
    @(negedge clk);
    #1 chk("bp_ready1", 32'(ii_ready), 32'b0010);
    exp_q.push_back('{core: 2'd1, thread: 2'd1, value: 32'h2222_2222});
    @(negedge clk);
    ior_request_valid[1] = 1'b0; io_ack = 1'b1; io_read_data = 32'h2222_2222;
    #1 chk("bp_addr1", io_address, 32'hFFFF_0304);
    @(negedge clk);
    io_ack = 1'b0;
    #1 expect_resp("bp_resp1");

    // Reset in the middle of a bus access aborts it.
    @(negedge clk);
    set_req(2, 1'b1, 1'b0, 32'hFFFF_0400, 32'd0, 2'd2);
    #1 chk("rb_ready", 32'(ii_ready), 32'b0100);
    @(negedge clk);
    ior_request_valid[2] = 1'b0;
    #1 chk("rb_rd_en", 32'(io_read_en), 32'd1);
    reset = 1'b1;
    #1 check_all_zero("rb_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("rb_no_resp", 32'(ii_response_valid), 32'd0);
      chk("rb_no_strobe", 32'(io_read_en), 32'd0);
    end
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, 32'hFFFF_0500, 32'hCAFE_F00D, 2'd1);
    exp_q.push_back('{core: 2'd3, thread: 2'd1, value: 32'd0});
    #1 chk("rb_new_ready", 32'(ii_ready), 32'b1000);
    @(negedge clk);
    ior_request_valid[3] = 1'b0; io_ack = 1'b1;
    #1 chk("rb_wr_en", 32'(io_write_en), 32'd1);
    chk("rb_wdata", io_write_data, 32'hCAFE_F00D);
    @(negedge clk);
    io_ack = 1'b0;
    #1 expect_resp("rb_new_resp");
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
